// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard and stall controller for the 5-stage core. It produces the
//   write-enable and flush controls for the PC and the IF/ID, ID/EX and EX/MEM
//   pipeline registers. It resolves these conditions, highest priority first:
//   memory freezes, taken-branch squashes, load-use hazards, and HI/LO hazards
//   while a multi-cycle mult/div occupies EX.
//
// Parameters
//   MULDIV_CYCLES  EX occupancy of a mult/div in cycles (2..63)
//   PERF_W         width of the saturating stall-cycle counter
//
// Ports
//   clock            pipeline clock, rising edge
//   reset            asynchronous active-low reset
//   id_rs, id_rt     source register fields of the ID instruction
//   id_uses_rt       ID instruction reads rt
//   id_muldiv_start  ID instruction is a mult/div
//   id_hilo_use      ID instruction is mfhi/mflo
//   ex_memread       EX instruction is a load
//   ex_rt            destination register of the EX load
//   branch_taken     EX branch/jump resolved taken
//   mem_stall        memory not ready, freeze everything
//   pc_wen, ifid_wen, idex_wen, exmem_wen   register write enables
//   ifid_flush, idex_flush                  bubble insertion
//   muldiv_busy      registered, high while a mult/div occupies EX
//   stall_count      saturating count of cycles with pc_wen low
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int PERF_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_muldiv_start,
  input  logic              id_hilo_use,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic              branch_taken,
  input  logic              mem_stall,
  output logic              pc_wen,
  output logic              ifid_wen,
  output logic              ifid_flush,
  output logic              idex_wen,
  output logic              idex_flush,
  output logic              exmem_wen,
  output logic              muldiv_busy,
  output logic [PERF_W-1:0] stall_count
);

  typedef enum logic {RUN = 1'b0, MDWAIT = 1'b1} state_t;

  localparam logic [5:0] MD_LOAD = 6'(MULDIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [5:0]  md_cnt, md_cnt_nxt;
  logic        load_use;
  logic        hilo_haz;
  logic        md_go;

  // Hazard detection. Register 0 is hardwired, so a load "to r0" never hazards.
  always_comb begin
    load_use = ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // A second mult/div in ID also has to wait for the unit to drain.
    hilo_haz = (state == MDWAIT) && (id_hilo_use || id_muldiv_start);
  end

  // Prioritised control outputs.
  always_comb begin
    pc_wen     = 1'b1;
    ifid_wen   = 1'b1;
    ifid_flush = 1'b0;
    idex_wen   = 1'b1;
    idex_flush = 1'b0;
    exmem_wen  = 1'b1;
    md_go      = 1'b0;
    if (mem_stall) begin
      pc_wen    = 1'b0;
      ifid_wen  = 1'b0;
      idex_wen  = 1'b0;
      exmem_wen = 1'b0;
    end else if (branch_taken) begin
      // The ID instruction is squashed, so any mult/div start in ID is dropped.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use || hilo_haz) begin
      pc_wen     = 1'b0;
      ifid_wen   = 1'b0;
      idex_flush = 1'b1;
    end else begin
      md_go = (state == RUN) && id_muldiv_start;
    end
  end

  // Next-state logic. The occupancy counter keeps running through memory
  // freezes because the mult/div unit itself is not frozen.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      RUN: begin
        if (md_go) begin
          state_nxt  = MDWAIT;
          md_cnt_nxt = MD_LOAD;
        end
      end
      MDWAIT: begin
        if (md_cnt == 6'd0) begin
          state_nxt = RUN;
        end else begin
          md_cnt_nxt = md_cnt - 6'd1;
        end
      end
      default: begin
        state_nxt  = RUN;
        md_cnt_nxt = 6'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      md_cnt <= 6'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Performance counter: counts frozen-PC cycles, sticks at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!pc_wen && (stall_count != '1)) begin
      stall_count <= stall_count + PERF_W'(1);
    end
  end

  assign muldiv_busy = (state == MDWAIT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl (MULDIV_CYCLES=4, PERF_W=3 so that the
//   stall counter saturation is reachable quickly).
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MDC = 4;
  localparam int PW  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, id_muldiv_start, id_hilo_use;
  logic          ex_memread, branch_taken, mem_stall;
  logic          pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen;
  logic          muldiv_busy;
  logic [PW-1:0] stall_count;

  int n_vec = 0;
  int n_bad = 0;

  hazard_ctrl #(.MULDIV_CYCLES(MDC), .PERF_W(PW)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_muldiv_start(id_muldiv_start), .id_hilo_use(id_hilo_use),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
    .idex_wen(idex_wen), .idex_flush(idex_flush), .exmem_wen(exmem_wen),
    .muldiv_busy(muldiv_busy), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  // Expected control pattern {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen}
  localparam logic [5:0] C_OK = 6'b110101;
  localparam logic [5:0] C_LU = 6'b000111;
  localparam logic [5:0] C_BR = 6'b111111;
  localparam logic [5:0] C_MS = 6'b000000;

  typedef struct packed {
    logic       ms, br, mr;
    logic [4:0] xrt, rs, rt;
    logic       urt, mds, hilo;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [5:0] ctl();
    return {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_muldiv_start = 1'b0; id_hilo_use = 1'b0;
    ex_memread = 1'b0; branch_taken = 1'b0; mem_stall = 1'b0;
  endtask

  // Advance one clock; inputs are then changed 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  logic [PW-1:0] exp_sc;

  initial begin
    // name                      ms    br    mr    xrt   rs    rt    urt   mds   hilo  exp
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_OK}; // idle
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, C_LU}; // load-use rs
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, C_OK}; // load gone
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, C_LU}; // load-use rt
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, C_OK}; // rt unused
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, C_OK}; // r0 never hazards
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, C_BR}; // branch beats load-use
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_MS}; // mem_stall beats branch
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_BR}; // flush after freeze
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, C_MS}; // mem_stall beats load-use
    vecs[10] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_BR}; // muldiv squashed by branch
    vecs[11] = '{1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, C_LU}; // muldiv held by load-use
    vecs[12] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_MS}; // muldiv held by mem_stall
    vecs[13] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_OK}; // hilo in RUN is free
    vecs[14] = '{1'b0, 1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, C_LU}; // r31 both sources

    idle();
    reset = 1'b0;
    #2;
    // Values while reset is held
    chk("rst_ctl", 32'(ctl()), 32'(C_OK));
    chk("rst_busy", 32'(muldiv_busy), 32'd0);
    chk("rst_sc", 32'(stall_count), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Table-driven single-cycle vectors from RUN
    exp_sc = '0;
    for (int i = 0; i < 15; i++) begin
      mem_stall = vecs[i].ms; branch_taken = vecs[i].br; ex_memread = vecs[i].mr;
      ex_rt = vecs[i].xrt; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_uses_rt = vecs[i].urt; id_muldiv_start = vecs[i].mds; id_hilo_use = vecs[i].hilo;
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp));
      if (!vecs[i].exp[5] && exp_sc != '1) exp_sc = exp_sc + 1'b1;
      tick();
      chk($sformatf("vec%0d_busy", i), 32'(muldiv_busy), 32'd0);
      chk($sformatf("vec%0d_sc", i), 32'(stall_count), 32'(exp_sc));
    end
    // 7 stalling vectors above: 1,3,7,9,11,12,14 -> counter at 7 (saturated at 3 bits)
    chk("tbl_sc_total", 32'(stall_count), 32'd7);

    // Saturation: more freeze cycles keep the counter at all-ones
    mem_stall = 1'b1;
    tick(); tick(); tick();
    chk("sat_sc", 32'(stall_count), 32'd7);
    idle();

    // Mult/div occupancy with mfhi waiting in ID
    do_reset();
    id_muldiv_start = 1'b1;
    #1;
    chk("md_start_ctl", 32'(ctl()), 32'(C_OK));
    tick();
    id_muldiv_start = 1'b0;
    id_hilo_use = 1'b1;
    for (int c = 0; c < MDC; c++) begin
      #1;
      chk($sformatf("md_busy%0d", c), 32'(muldiv_busy), 32'd1);
      chk($sformatf("md_ctl%0d", c), 32'(ctl()), 32'(C_LU));
      tick();
    end
    #1;
    chk("md_done_busy", 32'(muldiv_busy), 32'd0);
    chk("md_done_ctl", 32'(ctl()), 32'(C_OK));
    chk("md_done_sc", 32'(stall_count), 32'd4);
    idle();

    // Occupancy counter keeps running under mem_stall; branch in MDWAIT ignored
    do_reset();
    id_muldiv_start = 1'b1;
    tick();
    id_muldiv_start = 1'b0;
    mem_stall = 1'b1;
    tick(); tick();
    mem_stall = 1'b0;
    branch_taken = 1'b1;
    #1;
    chk("mdms_busy", 32'(muldiv_busy), 32'd1);
    chk("mdms_ctl", 32'(ctl()), 32'(C_BR));
    tick();
    branch_taken = 1'b0;
    #1;
    chk("mdms_last", 32'(muldiv_busy), 32'd1);
    tick();
    chk("mdms_end", 32'(muldiv_busy), 32'd0);
    chk("mdms_sc", 32'(stall_count), 32'd2);

    // Asynchronous reset two cycles into MDWAIT
    do_reset();
    id_muldiv_start = 1'b1;
    tick();
    id_muldiv_start = 1'b0;
    id_hilo_use = 1'b1;
    tick();
    tick();
    chk("ar_pre_busy", 32'(muldiv_busy), 32'd1);
    chk("ar_pre_sc", 32'(stall_count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_busy", 32'(muldiv_busy), 32'd0);
    chk("ar_sc", 32'(stall_count), 32'd0);
    chk("ar_ctl", 32'(ctl()), 32'(C_OK));
    idle();
    tick();
    reset = 1'b1;
    tick();
    id_hilo_use = 1'b1;
    #1;
    chk("ar_post_busy", 32'(muldiv_busy), 32'd0);
    chk("ar_post_ctl", 32'(ctl()), 32'(C_OK));
    tick();
    chk("ar_post_sc", 32'(stall_count), 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
